// File: rtl/mdu_req_arbiter.sv
// Round-robin sharing of one MDU between the processor (port 0) and host (port 1),
// with an in-order owner-tag FIFO for response steering. Define MDU_ARB_STATS_EN for grant/conflict counters.
module mdu_req_arbiter #(
  parameter int p_req_nbits    = 70,
  parameter int p_resp_nbits   = 35,
  parameter int p_max_inflight = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                host_en,
  input  logic                                req0_val,
  output logic                                req0_rdy,
  input  logic [p_req_nbits-1:0]              req0_msg,
  input  logic                                req1_val,
  output logic                                req1_rdy,
  input  logic [p_req_nbits-1:0]              req1_msg,
  output logic                                resp0_val,
  input  logic                                resp0_rdy,
  output logic [p_resp_nbits-1:0]             resp0_msg,
  output logic                                resp1_val,
  input  logic                                resp1_rdy,
  output logic [p_resp_nbits-1:0]             resp1_msg,
  output logic                                mdureq_val,
  input  logic                                mdureq_rdy,
  output logic [p_req_nbits-1:0]              mdureq_msg,
  input  logic                                mduresp_val,
  output logic                                mduresp_rdy,
  input  logic [p_resp_nbits-1:0]             mduresp_msg,
  output logic [$clog2(p_max_inflight):0]     inflight
`ifdef MDU_ARB_STATS_EN
  ,
  output logic [31:0]                         grant0_count,
  output logic [31:0]                         grant1_count,
  output logic [31:0]                         conflict_count
`endif
);

  localparam int PTR_W = $clog2(p_max_inflight);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(p_max_inflight);

  logic [p_max_inflight-1:0] tag_q, tag_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      prio_q, prio_d;

  logic e0, e1, gnt1, full, empty, issue, pop, head;

  // Request side: grant, issue, and full back-pressure from the registered count only.
  always_comb begin
    e0         = req0_val;
    e1         = req1_val && host_en;
    gnt1       = e1 && (!e0 || prio_q);
    full       = (cnt_q == FULL_CNT);
    empty      = (cnt_q == '0);
    mdureq_val = reset && (e0 || e1) && !full;
    mdureq_msg = gnt1 ? req1_msg : req0_msg;
    req0_rdy   = reset && e0 && !gnt1 && mdureq_rdy && !full;
    req1_rdy   = reset && gnt1 && mdureq_rdy && !full;
    issue      = mdureq_val && mdureq_rdy;
  end

  // Response side: the oldest outstanding owner tag picks the destination.
  always_comb begin
    head        = tag_q[rd_ptr_q];
    resp0_msg   = mduresp_msg;
    resp1_msg   = mduresp_msg;
    resp0_val   = reset && !empty && !head && mduresp_val;
    resp1_val   = reset && !empty &&  head && mduresp_val;
    mduresp_rdy = reset && !empty && (head ? resp1_rdy : resp0_rdy);
    pop         = mduresp_val && mduresp_rdy;
  end

  always_comb begin
    tag_d = tag_q;
    if (issue) tag_d[wr_ptr_q] = gnt1;
    wr_ptr_d = wr_ptr_q + PTR_W'(issue);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    cnt_d    = cnt_q + CNT_W'(issue) - CNT_W'(pop);
    prio_d   = issue ? !gnt1 : prio_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      prio_q   <= 1'b0;
    end else begin
      tag_q    <= tag_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      prio_q   <= prio_d;
    end
  end

  assign inflight = cnt_q;

`ifdef MDU_ARB_STATS_EN
  logic [31:0] grant0_count_q, grant0_count_d;
  logic [31:0] grant1_count_q, grant1_count_d;
  logic [31:0] conflict_count_q, conflict_count_d;

  always_comb begin
    grant0_count_d   = grant0_count_q + 32'(issue && !gnt1);
    grant1_count_d   = grant1_count_q + 32'(issue && gnt1);
    conflict_count_d = conflict_count_q + 32'(e0 && e1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant0_count_q   <= '0;
      grant1_count_q   <= '0;
      conflict_count_q <= '0;
    end else begin
      grant0_count_q   <= grant0_count_d;
      grant1_count_q   <= grant1_count_d;
      conflict_count_q <= conflict_count_d;
    end
  end

  assign grant0_count   = grant0_count_q;
  assign grant1_count   = grant1_count_q;
  assign conflict_count = conflict_count_q;
`endif

endmodule

// File: tb/tb_mdu_req_arbiter.sv
// Directed bench for mdu_req_arbiter: arbitration order, host gating, full stall,
// response steering and asynchronous reset, checked with immediate assertions.
module tb_mdu_req_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        host_en;
  logic        req0_val, req0_rdy, req1_val, req1_rdy;
  logic [69:0] req0_msg, req1_msg, mdureq_msg;
  logic        resp0_val, resp0_rdy, resp1_val, resp1_rdy;
  logic [34:0] resp0_msg, resp1_msg, mduresp_msg;
  logic        mdureq_val, mdureq_rdy, mduresp_val, mduresp_rdy;
  logic [2:0]  inflight;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mdu_req_arbiter dut (
    .clk(clk), .reset(reset), .host_en(host_en),
    .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg),
    .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg),
    .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg),
    .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg),
    .mdureq_val(mdureq_val), .mdureq_rdy(mdureq_rdy), .mdureq_msg(mdureq_msg),
    .mduresp_val(mduresp_val), .mduresp_rdy(mduresp_rdy), .mduresp_msg(mduresp_msg),
    .inflight(inflight)
  );

  task automatic chk(input string tag, input logic ok);
    checks++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL %s", tag);
    end
  endtask

  initial begin
    reset = 1'b0; host_en = 1'b0;
    req0_val = 1'b0; req1_val = 1'b0; req0_msg = '0; req1_msg = '0;
    resp0_rdy = 1'b0; resp1_rdy = 1'b0;
    mdureq_rdy = 1'b0; mduresp_val = 1'b0; mduresp_msg = '0;

    // Reset held: every handshake output low regardless of inputs.
    @(negedge clk);
    req0_val = 1'b1; req1_val = 1'b1; host_en = 1'b1; mdureq_rdy = 1'b1;
    mduresp_val = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
    #1;
    chk("rst_mdureq_val", mdureq_val === 1'b0);
    chk("rst_req0_rdy", req0_rdy === 1'b0);
    chk("rst_req1_rdy", req1_rdy === 1'b0);
    chk("rst_mduresp_rdy", mduresp_rdy === 1'b0);
    chk("rst_resp0_val", resp0_val === 1'b0);
    chk("rst_resp1_val", resp1_val === 1'b0);
    chk("rst_inflight", inflight === 3'd0);
    @(negedge clk);
    reset = 1'b1; mduresp_val = 1'b0;

    // Both ports streaming, responses returned one cycle behind.
    for (int k = 0; k < 6; k++) begin
      req0_msg = 70'(32'hA00 + k);
      req1_msg = 70'(32'hB00 + k);
      mduresp_val = (k > 0);
      mduresp_msg = 35'(32'h100 + k - 1);
      #1;
      chk("rr_mdureq_val", mdureq_val === 1'b1);
      chk("rr_mdureq_msg", mdureq_msg === 70'((k % 2 == 0) ? 32'hA00 + k : 32'hB00 + k));
      chk("rr_req0_rdy", req0_rdy === 1'((k % 2) == 0));
      chk("rr_req1_rdy", req1_rdy === 1'((k % 2) == 1));
      chk("rr_inflight", inflight === 3'((k == 0) ? 0 : 1));
      if (k > 0) begin
        chk("rr_resp0_val", resp0_val === 1'(((k - 1) % 2) == 0));
        chk("rr_resp1_val", resp1_val === 1'(((k - 1) % 2) == 1));
        chk("rr_mduresp_rdy", mduresp_rdy === 1'b1);
        chk("rr_resp_msg", ((((k - 1) % 2) == 0) ? resp0_msg : resp1_msg) === 35'(32'h100 + k - 1));
      end
      @(negedge clk);
    end
    req0_val = 1'b0; req1_val = 1'b0;
    mduresp_val = 1'b1; mduresp_msg = 35'h105;
    #1;
    chk("rr_last_resp1_val", resp1_val === 1'b1);
    chk("rr_last_resp0_val", resp0_val === 1'b0);
    chk("rr_last_resp1_msg", resp1_msg === 35'h105);
    chk("rr_last_mdureq_val", mdureq_val === 1'b0);
    chk("rr_last_inflight", inflight === 3'd1);
    @(negedge clk);
    mduresp_val = 1'b0;
    #1;
    chk("rr_drained", inflight === 3'd0);

    // Host disabled: port 1 never granted until host_en rises.
    host_en = 1'b0; req1_val = 1'b1; req1_msg = 70'hC0;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("hd_req1_rdy", req1_rdy === 1'b0);
      chk("hd_mdureq_val", mdureq_val === 1'b0);
      @(negedge clk);
    end
    host_en = 1'b1;
    #1;
    chk("he_mdureq_val", mdureq_val === 1'b1);
    chk("he_req1_rdy", req1_rdy === 1'b1);
    chk("he_mdureq_msg", mdureq_msg === 70'hC0);
    @(negedge clk);
    req1_val = 1'b0; mduresp_val = 1'b1; mduresp_msg = 35'hD0;
    #1;
    chk("he_inflight", inflight === 3'd1);
    chk("he_resp1_val", resp1_val === 1'b1);
    chk("he_resp1_msg", resp1_msg === 35'hD0);
    chk("he_resp0_val", resp0_val === 1'b0);
    @(negedge clk);
    mduresp_val = 1'b0;
    #1;
    chk("he_drained", inflight === 3'd0);

    // Fill to the inflight limit with responses blocked.
    resp0_rdy = 1'b0; resp1_rdy = 1'b0; req0_val = 1'b1; req0_msg = 70'hE0;
    for (int j = 0; j < 6; j++) begin
      #1;
      chk("full_req0_rdy", req0_rdy === 1'(j < 4));
      chk("full_inflight", inflight === 3'((j < 4) ? j : 4));
      @(negedge clk);
    end
    #1;
    chk("full_mdureq_val", mdureq_val === 1'b0);
    mduresp_val = 1'b1; resp0_rdy = 1'b1;
    #1;
    chk("full_pop_rdy", mduresp_rdy === 1'b1);
    chk("full_no_bypass", req0_rdy === 1'b0);
    @(negedge clk);
    mduresp_val = 1'b0;
    #1;
    chk("full_after_pop", inflight === 3'd3);
    chk("full_reissue_rdy", req0_rdy === 1'b1);
    chk("full_reissue_val", mdureq_val === 1'b1);
    @(negedge clk);
    req0_val = 1'b0;
    #1;
    chk("full_refilled", inflight === 3'd4);
    mduresp_val = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      chk("full_drain_resp0", resp0_val === 1'b1);
      @(negedge clk);
    end
    mduresp_val = 1'b0;
    #1;
    chk("full_drained", inflight === 3'd0);

    // Two host requests in flight, then host_en drops; head tag 1 blocks on resp1_rdy.
    host_en = 1'b1; req1_val = 1'b1; req1_msg = 70'hF0;
    #1;
    chk("h2_req1_rdy_a", req1_rdy === 1'b1);
    @(negedge clk);
    #1;
    chk("h2_req1_rdy_b", req1_rdy === 1'b1);
    chk("h2_inflight_1", inflight === 3'd1);
    @(negedge clk);
    req1_val = 1'b0; host_en = 1'b0; resp0_rdy = 1'b1; resp1_rdy = 1'b0;
    mduresp_val = 1'b1; mduresp_msg = 35'h0AA;
    #1;
    chk("h2_inflight_2", inflight === 3'd2);
    chk("hb_mduresp_rdy", mduresp_rdy === 1'b0);
    chk("hb_resp0_val", resp0_val === 1'b0);
    chk("hb_resp1_val", resp1_val === 1'b1);
    chk("hb_resp1_msg", resp1_msg === 35'h0AA);
    @(negedge clk);
    #1;
    chk("hb_held_inflight", inflight === 3'd2);
    chk("hb_held_resp0", resp0_val === 1'b0);
    resp1_rdy = 1'b1;
    #1;
    chk("hb_release_rdy", mduresp_rdy === 1'b1);
    @(negedge clk);
    mduresp_msg = 35'h0BB;
    #1;
    chk("h2_inflight_after1", inflight === 3'd1);
    chk("h2_second_resp1", resp1_val === 1'b1);
    chk("h2_second_msg", resp1_msg === 35'h0BB);
    chk("h2_second_resp0", resp0_val === 1'b0);
    @(negedge clk);
    #1;
    chk("h2_drained", inflight === 3'd0);
    chk("empty_mduresp_rdy", mduresp_rdy === 1'b0);
    chk("empty_resp0_val", resp0_val === 1'b0);
    chk("empty_resp1_val", resp1_val === 1'b0);
    @(negedge clk);
    #1;
    chk("empty_still_zero", inflight === 3'd0);
    mduresp_val = 1'b0;

    // Three in flight, then asynchronous reset mid-traffic.
    host_en = 1'b1; req0_val = 1'b1; req1_val = 1'b1;
    req0_msg = 70'h111; req1_msg = 70'h222; resp0_rdy = 1'b0; resp1_rdy = 1'b0;
    #1;
    chk("ar_msg_0", mdureq_msg === 70'h111);
    @(negedge clk);
    #1;
    chk("ar_msg_1", mdureq_msg === 70'h222);
    @(negedge clk);
    #1;
    chk("ar_msg_2", mdureq_msg === 70'h111);
    @(negedge clk);
    #1;
    chk("ar_inflight_3", inflight === 3'd3);
    chk("ar_msg_3", mdureq_msg === 70'h222);
    reset = 1'b0; mduresp_val = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
    #1;
    chk("ar_inflight_0", inflight === 3'd0);
    chk("ar_mdureq_val", mdureq_val === 1'b0);
    chk("ar_req0_rdy", req0_rdy === 1'b0);
    chk("ar_req1_rdy", req1_rdy === 1'b0);
    chk("ar_mduresp_rdy", mduresp_rdy === 1'b0);
    chk("ar_resp0_val", resp0_val === 1'b0);
    chk("ar_resp1_val", resp1_val === 1'b0);
    @(negedge clk);
    mduresp_val = 1'b0; reset = 1'b1;
    #1;
    chk("ar_post_req0_rdy", req0_rdy === 1'b1);
    chk("ar_post_req1_rdy", req1_rdy === 1'b0);
    chk("ar_post_msg", mdureq_msg === 70'h111);
    chk("ar_post_inflight", inflight === 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
